// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline stages.
//   fetch_state_t : request FSM of the instruction-fetch stage
//   NOP_INSTR     : bubble encoding, identical to the IF/ID flush encoding
//   INSTR_W       : instruction word width
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hFFFF_FFFF;

  // REQ  : request may be issued; waits for memory acceptance
  // WAIT : request accepted; waiting for read data
  // DROP : request accepted before a redirect; its data will be discarded
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time, and hands each fetched word plus its PC+4 to the IF/ID register.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   out_ready           : IF/ID accepts the presented instruction this cycle
//   redirect_valid/_pc  : taken branch/jump; bits [1:0] of the target ignored
//   imem_req/_addr      : fetch request and address (address always equals pc)
//   imem_ready          : memory accepts the request this cycle
//   imem_rvalid/_rdata  : read response, at least one cycle after acceptance
//   out_valid           : instr_out / pc_plus_four_out hold a real instruction
//   instr_out           : fetched word, NOP_INSTR when out_valid=0
//   pc_plus_four_out    : PC of instr_out + 4, zero when out_valid=0
//   fetch_state         : current FSM state, for observation only
//
// Handshakes: a request transfers on a cycle where imem_req && imem_ready; the
// address must then stay fixed until the response, and an unaccepted request
// may be withdrawn or retargeted. An instruction transfers to IF/ID on a cycle
// where out_valid && out_ready; until then the outputs are held stable.
module if_fetch #(
  parameter logic [31:0]               RESET_PC  = 32'h0000_0000,
  parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        out_ready,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        imem_req,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [cpu_pkg::INSTR_W-1:0] imem_rdata,
  output logic                        out_valid,
  output logic [cpu_pkg::INSTR_W-1:0] instr_out,
  output logic [31:0]                 pc_plus_four_out,
  output cpu_pkg::fetch_state_t       fetch_state
);
  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d, pc_inc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pcp4_q, pcp4_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               load;

  assign pc_inc = pc_q + 32'd4;  // modulo 2^32: FFFF_FFFC wraps to 0
  assign accept = imem_req && imem_ready;
  // A response in WAIT fills the slot; a redirect in the same cycle kills it.
  assign load   = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A redirect only changes where an accepted-but-unanswered
  // request ends up: it must still be drained, but its data is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ: begin
        if (accept) state_d = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)         state_d = REQ;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // Outputs. The request is gated by slot occupancy so a response always
  // finds the slot empty or being drained in that same cycle.
  always_comb begin
    imem_req  = (state_q == REQ) && !rst && (!valid_q || out_ready);
    imem_addr = pc_q;
    fetch_state = state_q;
    out_valid = valid_q;
    instr_out = instr_q;
    pc_plus_four_out = pcp4_q;
  end

  // PC and output slot. The slot registers hold the bubble values whenever
  // empty, so the outputs come straight from flops.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pcp4_d  = 32'd0;
    end else if (load) begin
      pc_d    = pc_inc;
      valid_d = 1'b1;
      instr_d = imem_rdata;
      pcp4_d  = pc_inc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pcp4_d  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory responder with random latency/readiness, an
// in-order program-stream reference (sequential from reset or the latest
// redirect target), a scoreboard monitor, and a second instance for PC wrap.
module tb_if_fetch;
  localparam logic [31:0] NOP    = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] MARK   = 32'hA5A5_0000;

  // ---------------- clock / DUT signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_plus_four_out;
  cpu_pkg::fetch_state_t fetch_state;

  initial forever #5 clk = ~clk;

  if_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .instr_out(instr_out),
    .pc_plus_four_out(pc_plus_four_out), .fetch_state(fetch_state)
  );

  // Wrap-around instance: always-ready memory and always-ready consumer.
  logic        w_rst = 1'b1;
  logic        w_ready = 1'b1;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'd0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ov;
  logic [31:0] w_instr;
  logic [31:0] w_pcp4;
  cpu_pkg::fetch_state_t w_state;

  if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(w_rst), .out_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .out_valid(w_ov), .instr_out(w_instr),
    .pc_plus_four_out(w_pcp4), .fetch_state(w_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          pops = 0;
  logic [63:0] exp_q[$];          // {instr, pc+4} in program order
  logic [31:0] acc_log[$];        // addresses accepted by memory
  logic [31:0] next_addr = RST_PC;

  // memory model state
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100;

  // per-cycle snapshot taken by the driver at negedge
  logic        acc_s, rv_s, req_s, ov_s;
  logic [31:0] addr_s;
  cpu_pkg::fetch_state_t st_s;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic o, input logic rd, input logic [31:0] tgt);
    rst = r;
    out_ready = o;
    redirect_valid = rd;
    redirect_pc = tgt;
    if (rd) begin
      exp_q.delete();
      next_addr = tgt & 32'hFFFF_FFFC;
    end
    if (r) begin
      exp_q.delete();
      next_addr = RST_PC;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_addr ^ MARK, next_addr + 32'd4});
      next_addr = next_addr + 32'd4;
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc_s = imem_req && imem_ready;
    rv_s  = imem_rvalid;
    req_s = imem_req;
    ov_s  = out_valid;
    addr_s = imem_addr;
    st_s  = fetch_state;
    if (acc_s) acc_log.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (rv_s) pend = 1'b0;
    if (acc_s) begin
      pend = 1'b1;
      pend_addr = addr_s;
      pend_cnt = int'($urandom_range(lat_min, lat_max));
    end
    if (pend && pend_cnt <= 1) begin
      imem_rvalid = 1'b1;
      imem_rdata = pend_addr ^ MARK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (pend) pend_cnt--;
    end
    imem_ready = !pend && ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic wait_accept(input string name);
    int k;
    k = 0;
    do begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      step();
      k++;
    end while (!acc_s && k < 30);
    if (!acc_s) timeout(name);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        p_rst, p_hold, p_req_hold;
    logic [63:0] p_data, e;
    logic [31:0] p_addr;
    p_rst = 0; p_hold = 0; p_req_hold = 0; p_data = 0; p_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) chk("req_during_rst", imem_req, 1'b0);
      if (p_rst) chk("valid_after_rst", out_valid, 1'b0);
      if (!out_valid) begin
        chk("bubble_instr", instr_out, NOP);
        chk("bubble_pcp4", pc_plus_four_out, 32'd0);
      end
      if (p_hold) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", {instr_out, pc_plus_four_out}, p_data);
      end
      if (p_req_hold) chk("req_addr_hold", imem_addr, p_addr);
      if (out_valid && !out_ready) chk("no_req_when_full", imem_req, 1'b0);
      if (out_valid && out_ready && !rst && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          timeout("out_data_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {instr_out, pc_plus_four_out}, e);
          pops++;
        end
      end
      p_rst = rst;
      p_hold = out_valid && !out_ready && !rst && !redirect_valid;
      p_data = {instr_out, pc_plus_four_out};
      p_req_hold = imem_req && !imem_ready && !rst && !redirect_valid;
      p_addr = imem_addr;
    end
  end

  // ---------------- wrap instance responder ----------------
  logic        w_acc;
  logic [31:0] w_a;
  logic [31:0] w_acc_log[$];
  logic        w_seen = 1'b0;
  logic [63:0] w_first = 64'd0;
  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 w_rst = 1'b0;
    forever begin
      @(negedge clk);
      w_acc = w_req && w_ready;
      w_a = w_addr;
      if (w_acc) w_acc_log.push_back(w_addr);
      if (w_ov && !w_seen) begin
        w_seen = 1'b1;
        w_first = {w_instr, w_pcp4};
      end
      @(posedge clk);
      #1;
      w_rvalid = w_acc;
      w_rdata = w_a ^ MARK;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset, then first fetch with the consumer stalled for five cycles.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      step();
      if (i < 2) begin
        chk("valid_before_resp", ov_s, 1'b0);
      end else begin
        chk("stall_out_valid", ov_s, 1'b1);
        chk("stall_no_req", req_s, 1'b0);
      end
    end
    // Release the stall; the third request (addr 8) gets a 2-cycle memory.
    for (int i = 0; i < 40 && acc_log.size() < 3; i++) begin
      if (acc_log.size() == 2) begin
        lat_min = 2;
        lat_max = 2;
      end
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      step();
    end
    if (acc_log.size() < 3) begin
      timeout("seq_addrs");
    end else begin
      chk("seq_addr0", acc_log[0], 32'h0);
      chk("seq_addr1", acc_log[1], 32'h4);
      chk("seq_addr2", acc_log[2], 32'h8);
    end

    // Redirect while waiting on the response for 8.
    drive(1'b0, 1'b1, 1'b1, 32'h100);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    chk("redir_wait_ov_drop", ov_s, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    chk("redir_wait_ov_req", ov_s, 1'b0);
    chk("redir_wait_req", req_s, 1'b1);
    chk("redir_wait_addr", addr_s, 32'h100);

    // Redirect coincident with rvalid, unaligned target.
    lat_min = 1;
    lat_max = 1;
    wait_accept("coinc_accept");
    drive(1'b0, 1'b1, 1'b1, 32'h203);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    chk("coinc_state", 64'(st_s), 64'(cpu_pkg::REQ));
    chk("coinc_req", req_s, 1'b1);
    chk("coinc_addr", addr_s, 32'h200);
    chk("coinc_ov", ov_s, 1'b0);

    // Reset while waiting; stale response arrives the cycle after reset.
    lat_min = 2;
    lat_max = 2;
    wait_accept("rst_wait_accept");
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    acc_log.delete();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    chk("stale_ov", ov_s, 1'b0);
    chk("stale_req", req_s, 1'b1);
    chk("stale_addr", addr_s, RST_PC);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    chk("stale_ignored", ov_s, 1'b0);
    if (acc_log.size() == 0) timeout("fresh_req");
    else chk("fresh_req_addr", acc_log[0], RST_PC);

    // Randomized traffic.
    lat_min = 1;
    lat_max = 3;
    rdy_pct = 70;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 5, $urandom_range(0, 4095));
      step();
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      step();
    end
    chk("random_progress", pops > 200, 1'b1);

    // Wrap-around instance results.
    if (w_acc_log.size() < 2) begin
      timeout("wrap_addrs");
    end else begin
      chk("wrap_addr0", w_acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_acc_log[1], 32'h0000_0000);
    end
    if (!w_seen) timeout("wrap_out");
    else chk("wrap_out", w_first, {32'hFFFF_FFFC ^ MARK, 32'h0000_0000});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
